// File: rtl/dmem_pkg.sv
// Shared opcodes, MMIO address, store-buffer entry type and byte-merge helper for the
// data-memory responder.
package dmem_pkg;

    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;
    localparam logic [5:0]  OP_SB     = 6'h28;
    localparam logic [31:0] MMIO_ADDR = 32'h0000_FFFC;

    localparam int unsigned IDX_W = 30;

    // data holds the store bytes already placed in their lanes
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [31:0]      data;
        logic [3:0]       mask;
    } sb_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// Circular store-buffer FIFO with simultaneous push/pop; exposes every slot oldest-first
// so the responder can forward buffered bytes to loads.
module dmem_store_buf
    import dmem_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    localparam int unsigned CW = $clog2(SB_DEPTH + 1),
    localparam int unsigned PW = $clog2(SB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  sb_entry_t                  push_entry,
    output sb_entry_t [SB_DEPTH-1:0]   entries,
    output logic      [SB_DEPTH-1:0]   valid,
    output logic      [CW-1:0]         count
);

    sb_entry_t     mem_q [SB_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // When full, push and pop share the head slot; the old head is read before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_entry;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop) head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            entries[i] = mem_q[head_q + PW'(i)];
            valid[i]   = (CW'(i) < count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_store_responder.sv
// Single-cycle data-memory responder: stores are buffered and drained on non-load cycles,
// loads forward buffered bytes. Optional MMIO register enabled by DMEM_MMIO_EN.
module dmem_store_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned SB_DEPTH    = 4,
    localparam int unsigned CW = $clog2(SB_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [31:0]   addr,
    input  logic [31:0]   writedata,
    input  logic [5:0]    opcode,
    output logic [31:0]   readdata,
    output logic [CW-1:0] sb_count,
    output logic          sb_empty,
    output logic [31:0]   mmio_out
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);

    logic [IW-1:0]             widx;
    logic                      is_load, drain, push, mmio_hit;
    sb_entry_t                 new_entry;
    sb_entry_t [SB_DEPTH-1:0]  sb_entries;
    logic [SB_DEPTH-1:0]       sb_valid;
    logic [31:0]               ram [DEPTH_WORDS];
    logic [31:0]               fwd_word;
    logic                      unused_addr;

    assign widx        = addr[IW+1:2];
    assign unused_addr = ^addr[31:IW+2];
    assign is_load     = !memwrite && (opcode == OP_LW);
    assign drain       = !is_load && !sb_empty;
    assign push        = memwrite && !mmio_hit;
    assign sb_empty    = (sb_count == '0);

`ifdef DMEM_MMIO_EN
    assign mmio_hit = (addr == MMIO_ADDR);
`else
    assign mmio_hit = 1'b0;
`endif

    always_comb begin
        new_entry.index = IDX_W'(widx);
        if (opcode == OP_SB) begin
            new_entry.mask = 4'b0001 << addr[1:0];
            new_entry.data = {4{writedata[7:0]}};
        end else begin
            new_entry.mask = 4'hF;
            new_entry.data = writedata;
        end
    end

    dmem_store_buf #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (drain),
        .push_entry (new_entry),
        .entries    (sb_entries),
        .valid      (sb_valid),
        .count      (sb_count)
    );

    // Reset discards a drain in flight, so the RAM write is gated too.
    always_ff @(posedge clk) begin
        if (!reset && drain) begin
            ram[sb_entries[0].index[IW-1:0]] <= merge_bytes(ram[sb_entries[0].index[IW-1:0]],
                                                            sb_entries[0].data,
                                                            sb_entries[0].mask);
        end
    end

    // Oldest-to-youngest overlay so the youngest store wins each lane.
    always_comb begin
        fwd_word = ram[widx];
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && (sb_entries[i].index == IDX_W'(widx))) begin
                fwd_word = merge_bytes(fwd_word, sb_entries[i].data, sb_entries[i].mask);
            end
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_q <= '0;
        end else if (memwrite && mmio_hit) begin
            mmio_q <= merge_bytes(mmio_q, new_entry.data, new_entry.mask);
        end
    end

    assign mmio_out = mmio_q;
    assign readdata = mmio_hit ? mmio_q : fwd_word;
`else
    assign mmio_out = '0;
    assign readdata = fwd_word;
`endif

endmodule
